// File: rtl/int_sequencer_pkg.sv
// int_sequencer_pkg: major/minor state encodings, opcode constants and entry FSM type
package int_sequencer_pkg;
  localparam logic [3:0] ST_F0 = 4'd0, ST_F1 = 4'd1, ST_F2 = 4'd2, ST_F3 = 4'd3;
  localparam logic [3:0] ST_D0 = 4'd4, ST_D1 = 4'd5, ST_D2 = 4'd6, ST_D3 = 4'd7;
  localparam logic [3:0] ST_E0 = 4'd8, ST_E1 = 4'd9, ST_E2 = 4'd10, ST_E3 = 4'd11;
  localparam logic [3:0] ST_H0 = 4'd12, ST_H1 = 4'd13, ST_H2 = 4'd14, ST_H3 = 4'd15;
  localparam logic [2:0] OP_JMS = 3'o4;
  localparam logic [11:0] FORCED_INSTR = {OP_JMS, 9'o000};
  typedef enum logic [1:0] {IDLE = 2'd0, PENDING = 2'd1, ACTIVE = 2'd2} fsm_t;
  function automatic logic is_halt_state(input logic [3:0] s);
    return s[3:2] == 2'b11;
  endfunction
endpackage

// File: rtl/int_sequencer_irq_sync.sv
// irq_sync: multi-stage synchroniser on device request lines plus registered mask-OR
module irq_sync #(
  parameter int N_IRQ = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_lines,
  input  logic [N_IRQ-1:0] irq_mask,
  output logic [N_IRQ-1:0] masked,
  output logic             irq
);
  logic [SYNC_STAGES-1:0][N_IRQ-1:0] stages;
  assign masked = stages[SYNC_STAGES-1] & irq_mask;
  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= '0;
      irq <= 1'b0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], irq_lines};
      irq <= |masked;
    end
  end
endmodule

// File: rtl/int_sequencer.sv
// int_sequencer: decides interrupt entry at instruction boundaries and frames the forced JMS cycle
module int_sequencer
  import int_sequencer_pkg::*;
#(
  parameter int N_IRQ = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       state,
  input  logic             clear,
  input  logic             run,
  input  logic             instr_done,
  input  logic [N_IRQ-1:0] irq_lines,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             int_ena,
  input  logic             int_inh,
  output logic             irq,
  output logic             int_take,
  output logic             int_in_prog,
  output logic             force_jms,
  output logic             int_lost,
  output logic [N_IRQ-1:0] irq_src
);
  logic rst_any;
  logic [N_IRQ-1:0] sync_masked;
  fsm_t fsm;
  assign rst_any = reset | clear;
  irq_sync #(.N_IRQ(N_IRQ), .SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
    .clk(clk),
    .rst(rst_any),
    .irq_lines(irq_lines),
    .irq_mask(irq_mask),
    .masked(sync_masked),
    .irq(irq)
  );
  assign int_take = ~rst_any && fsm == IDLE && instr_done && run && int_ena && ~int_inh && irq
                    && ~is_halt_state(state);
  // E0 is seen while still PENDING, so it is folded in to cover the whole E0..E3 window
  assign int_in_prog = ~rst_any && (fsm == ACTIVE || (fsm == PENDING && state == ST_E0));
  assign force_jms = int_in_prog;
  always_ff @(posedge clk) begin
    if (rst_any) begin
      fsm <= IDLE;
      int_lost <= 1'b0;
      irq_src <= '0;
    end else if (int_take) begin
      fsm <= PENDING;
      irq_src <= sync_masked;
    end else if (fsm == PENDING && state == ST_E0) begin
      fsm <= ACTIVE;
    end else if (fsm == PENDING && state == ST_F0) begin
      fsm <= IDLE;
      int_lost <= 1'b1;
    end else if (fsm == ACTIVE && state == ST_E3) begin
      fsm <= IDLE;
    end
  end
endmodule
